fifo_word_packer: RTL and testbench
===================================

// Module: fifo_word_packer
// PURPOSE
//  Downstream consumer of the 16x8 byte FIFO. Pops bytes through the FIFO read port
//  (renb/dout/empty) and packs them into little-endian 32-bit words with byte-keep.
//  Presents the words on a valid/ready stream to the bus-side logic.
//  Emits partial words on an explicit flush or after an idle timeout.
// PARAMETERS
//  BYTES_PER_WORD  4   bytes packed per output word; m_data width = 8*BYTES_PER_WORD
//  TIMEOUT_CYCLES  16  idle cycles with FIFO empty before a partial word is emitted; 0 disables
// PORTS
//  clk         in   1    single clock; all state rises on posedge clk
//  reset       in   1    asynchronous, active-high reset
//  fifo_empty  in   1    FIFO empty flag
//  fifo_dout   in   8    FIFO read data, valid the cycle after an accepted renb
//  fifo_renb   out  1    FIFO read enable (combinational from state)
//  flush       in   1    one-cycle request to emit the current partial word
//  m_valid     out  1    output word valid
//  m_ready     in   1    downstream accept
//  m_data      out  32   packed word; lane 0 [7:0] holds the first byte popped
//  m_keep      out  4    per-lane byte valid; always contiguous from lane 0
// BEHAVIOUR
//  Reset (async): state=REQ, byte_cnt=0, idle_cnt=0, flush_pend=0.
//   m_valid=0, m_data=0, m_keep=0, fifo_renb=0.
//   A word held in EMIT when reset asserts is dropped.
//   System reset must stay high for >=2 clk edges because the FIFO resets synchronously.
//  FSM states: REQ, CAP, EMIT.
//  REQ:
//   - byte_cnt==BYTES_PER_WORD -> go to EMIT.
//   - else if (flush_pend or timeout) and byte_cnt>0 -> go to EMIT.
//   - else if (flush_pend or timeout) and byte_cnt==0 -> clear flush_pend; stay in REQ.
//   - else if !fifo_empty -> fifo_renb=1; go to CAP.
//   - else stay in REQ.
//  CAP:
//   - Write fifo_dout into lane byte_cnt, set keep[byte_cnt], byte_cnt++.
//   - Go to EMIT if the new byte_cnt==BYTES_PER_WORD, else go to REQ.
//  EMIT:
//   - m_valid=1. m_data/m_keep stay stable until m_valid&&m_ready.
//   - On the handshake: clear byte_cnt, lanes, keep, flush_pend and idle_cnt; go to REQ.
//   - No back-to-back emit: the next word needs at least 2 further cycles.
//  fifo_renb is never high in 2 consecutive cycles, because REQ->CAP is mandatory.
//   This guarantees the upstream writer a write slot every other cycle,
//   since the FIFO gives reads priority over writes.
//  fifo_renb is never asserted while fifo_empty=1, so a garbage byte is never captured.
//  Read latency: fifo_renb in cycle N -> byte captured at the end of cycle N+1.
//  Full-word latency with the FIFO pre-filled: 8 cycles from REQ to m_valid.
//  Unused lanes of a partial word are driven 0.
//  flush:
//   - Latched into flush_pend in any state.
//   - A flush during CAP is honoured at the next REQ, after the capture.
//   - A flush during EMIT is cleared at the handshake and has no extra effect.
//  idle_cnt:
//   - Counts REQ cycles with byte_cnt>0 and fifo_empty=1; cleared on any capture.
//   - timeout = (idle_cnt==TIMEOUT_CYCLES-1) && TIMEOUT_CYCLES!=0.
//   - Saturates; no wrap.
//  Counter widths: byte_cnt is $clog2(BYTES_PER_WORD+1) bits;
//   idle_cnt is $clog2(TIMEOUT_CYCLES+1) bits.
// STRUCTURE
//  Shared fifo_pkg holds:
//   - typedef enum logic [1:0] {REQ, CAP, EMIT} packer_state_t
//   - localparam FIFO_DATA_W = 8
//   - localparam FIFO_DEPTH = 16
//  Single module. The idle timeout counter may optionally be split into
//  packer_idle_timer (en, clr -> expired).
//  Concurrent assertions to include:
//   - no renb on 2 consecutive cycles
//   - no renb while fifo_empty
//   - m_data/m_keep stable while m_valid && !m_ready
//   - m_keep contiguous and nonzero when m_valid
//  Cover: full word, partial word via flush, partial word via timeout,
//   m_ready backpressure >=3 cycles.
// TESTING
//  1 Write 11,22,33,44 into the FIFO; m_ready=1
//    -> one word m_data=32'h44332211, m_keep=4'hF; FIFO empty afterwards.
//  2 Write 8 bytes A0..A7; hold m_ready=0 for 5 cycles at the first m_valid
//    -> m_data=32'hA3A2A1A0 held stable; then 32'hA7A6A5A4.
//  3 Write 2 bytes 5A,C3; pulse flush after both are captured
//    -> m_data=32'h0000C35A, m_keep=4'h3.
//  4 Write 1 byte 7E, then nothing, with TIMEOUT_CYCLES=16
//    -> m_valid rises 16 cycles after the capture; m_keep=4'h1.
//  5 Writer drives wenb every cycle for 32 bytes while the packer drains
//    -> no byte lost or reordered; renb never high on consecutive cycles.
//  6 Assert reset in EMIT (m_ready=0)
//    -> m_valid=0 in the same cycle, outputs zero; after release, fresh packing restarts at lane 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the 16x8 byte FIFO and its downstream word packer.
package fifo_pkg;

    localparam int unsigned FIFO_DATA_W = 8;
    localparam int unsigned FIFO_DEPTH  = 16;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        CAP  = 2'd1,
        EMIT = 2'd2
    } packer_state_t;

endpackage

// File: rtl/fifo_word_packer.sv
// Pops bytes from the byte FIFO and packs them little-endian into words with byte-keep.
// Partial words leave on flush or after an idle timeout with the FIFO empty.
module fifo_word_packer
    import fifo_pkg::*;
#(
    parameter int unsigned BYTES_PER_WORD = 4,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          fifo_empty,
    input  logic [FIFO_DATA_W-1:0]        fifo_dout,
    output logic                          fifo_renb,
    input  logic                          flush,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [8*BYTES_PER_WORD-1:0]   m_data,
    output logic [BYTES_PER_WORD-1:0]     m_keep
);

    localparam int unsigned CNT_W  = $clog2(BYTES_PER_WORD + 1);
    // A zero timeout would give a zero-width counter; keep one bit and gate it off instead.
    localparam int unsigned IDLE_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(BYTES_PER_WORD);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT_CYCLES);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);
    localparam bit                TO_EN     = (TIMEOUT_CYCLES != 0);

    packer_state_t                  state_q, state_d;
    logic [CNT_W-1:0]               byte_cnt_q, byte_cnt_d;
    logic [IDLE_W-1:0]              idle_cnt_q, idle_cnt_d;
    logic                           flush_pend_q, flush_pend_d;
    logic [8*BYTES_PER_WORD-1:0]    data_q, data_d;
    logic [BYTES_PER_WORD-1:0]      keep_q, keep_d;
    logic                           timeout;

    assign timeout = TO_EN && (idle_cnt_q == IDLE_LAST);
    assign m_data  = data_q;
    assign m_keep  = keep_q;

    // Next-state, lane capture and handshake outputs.
    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        idle_cnt_d   = idle_cnt_q;
        flush_pend_d = flush_pend_q | flush;
        data_d       = data_q;
        keep_d       = keep_q;
        fifo_renb    = 1'b0;
        m_valid      = 1'b0;

        unique case (state_q)
            REQ: begin
                if (byte_cnt_q == FULL_CNT) begin
                    state_d = EMIT;
                end else if (flush_pend_q || timeout) begin
                    if (byte_cnt_q != '0) begin
                        state_d = EMIT;
                    end else begin
                        // Nothing to flush; a flush arriving right now still gets latched.
                        flush_pend_d = flush;
                    end
                end else if (!fifo_empty) begin
                    fifo_renb = 1'b1;
                    state_d   = CAP;
                end
                if ((byte_cnt_q != '0) && fifo_empty && (idle_cnt_q != IDLE_MAX)) begin
                    idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                end
            end
            CAP: begin
                for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
                    if (byte_cnt_q == CNT_W'(i)) begin
                        data_d[8*i +: 8] = fifo_dout;
                        keep_d[i]        = 1'b1;
                    end
                end
                byte_cnt_d = byte_cnt_q + CNT_W'(1);
                idle_cnt_d = '0;
                state_d    = (byte_cnt_d == FULL_CNT) ? EMIT : REQ;
            end
            EMIT: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    byte_cnt_d   = '0;
                    idle_cnt_d   = '0;
                    flush_pend_d = 1'b0;
                    data_d       = '0;
                    keep_d       = '0;
                    state_d      = REQ;
                end
            end
            default: begin
                state_d = REQ;
            end
        endcase
    end

    // State registers; reset drops any word held in EMIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= REQ;
            byte_cnt_q   <= '0;
            idle_cnt_q   <= '0;
            flush_pend_q <= 1'b0;
            data_q       <= '0;
            keep_q       <= '0;
        end else begin
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            flush_pend_q <= flush_pend_d;
            data_q       <= data_d;
            keep_q       <= keep_d;
        end
    end

    // Protocol checks and coverage.
    logic [BYTES_PER_WORD-1:0] keep_inc;
    assign keep_inc = m_keep + BYTES_PER_WORD'(1);

    a_renb_not_consecutive: assert property (@(posedge clk) disable iff (reset)
        fifo_renb |=> !fifo_renb);
    a_renb_not_empty: assert property (@(posedge clk) disable iff (reset)
        fifo_renb |-> !fifo_empty);
    a_out_stable: assert property (@(posedge clk) disable iff (reset)
        (m_valid && !m_ready) |=> ($stable(m_data) && $stable(m_keep)));
    a_keep_contig: assert property (@(posedge clk) disable iff (reset)
        m_valid |-> ((m_keep != '0) && ((keep_inc & m_keep) == '0)));

    c_full_word: cover property (@(posedge clk) disable iff (reset)
        m_valid && m_ready && (&m_keep));
    c_flush_partial: cover property (@(posedge clk) disable iff (reset)
        (state_q == REQ) && flush_pend_q && (byte_cnt_q != '0) && (byte_cnt_q != FULL_CNT));
    c_timeout_partial: cover property (@(posedge clk) disable iff (reset)
        (state_q == REQ) && timeout && !flush_pend_q && (byte_cnt_q != '0));
    c_backpressure: cover property (@(posedge clk) disable iff (reset)
        (m_valid && !m_ready) [*3]);

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed bench for fifo_word_packer with a behavioural 16x8 FIFO in front of it.
module tb_fifo_word_packer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;
    logic        fifo_renb;
    logic        flush = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic [3:0]  m_keep;

    logic        wenb = 1'b0;
    logic [7:0]  wdata = 8'h00;
    logic        wr_acc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fifo_word_packer #(
        .BYTES_PER_WORD (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_renb  (fifo_renb),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_keep     (m_keep)
    );

    // Behavioural FIFO: synchronous reset, reads win over writes.
    logic [7:0] fmem [16];
    logic [4:0] fcnt;
    logic [3:0] frd, fwr;
    logic       rd_acc;

    assign fifo_empty = (fcnt == 5'd0);
    assign rd_acc     = fifo_renb && !fifo_empty;
    assign wr_acc     = wenb && !fifo_renb && (fcnt != 5'd16);

    always @(posedge clk) begin
        if (reset) begin
            fcnt      <= 5'd0;
            frd       <= 4'd0;
            fwr       <= 4'd0;
            fifo_dout <= 8'h00;
        end else begin
            if (rd_acc) begin
                fifo_dout <= fmem[frd];
                frd       <= frd + 4'd1;
            end
            if (wr_acc) begin
                fmem[fwr] <= wdata;
                fwr       <= fwr + 4'd1;
            end
            if (wr_acc && !rd_acc) fcnt <= fcnt + 5'd1;
            else if (rd_acc && !wr_acc) fcnt <= fcnt - 5'd1;
        end
    end

    // Read-port rule monitor.
    logic renb_prev;
    int   renb_consec = 0;
    int   renb_empty  = 0;
    always @(posedge clk) begin
        if (reset) begin
            renb_prev <= 1'b0;
        end else begin
            if (fifo_renb && renb_prev) renb_consec <= renb_consec + 1;
            if (fifo_renb && fifo_empty) renb_empty <= renb_empty + 1;
            renb_prev <= fifo_renb;
        end
    end

    // Word collector: records every accepted output word.
    logic [31:0] wq_data [$];
    logic [3:0]  wq_keep [$];
    always @(negedge clk) begin
        if (!reset && m_valid && m_ready) begin
            wq_data.push_back(m_data);
            wq_keep.push_back(m_keep);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        int   n  = 0;
        logic ok = 1'b0;
        wenb  = 1'b1;
        wdata = b;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = wr_acc;
            step();
            n++;
        end
        wenb = 1'b0;
        check("push_accept", {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_valid(input string tag, input int max);
        int n = 0;
        while (!m_valid && n < max) begin
            step();
            n++;
        end
        check(tag, {31'd0, m_valid}, 32'd1);
    endtask

    task automatic wait_keep(input string tag, input logic [3:0] k, input int max);
        int n = 0;
        while (m_keep != k && n < max) begin
            step();
            n++;
        end
        check(tag, {28'd0, m_keep}, {28'd0, k});
    endtask

    task automatic wait_words(input string tag, input int cnt, input int max);
        int n = 0;
        while (wq_data.size() < cnt && n < max) begin
            step();
            n++;
        end
        check(tag, wq_data.size(), cnt);
    endtask

    task automatic clear_words();
        wq_data.delete();
        wq_keep.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0]  bytes5 [32];
        logic [31:0] exp_w;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {31'd0, m_valid}, 32'd0);
        check("rst_data", m_data, 32'd0);
        check("rst_keep", {28'd0, m_keep}, 32'd0);
        check("rst_renb", {31'd0, fifo_renb}, 32'd0);
        reset = 1'b0;
        step();

        // 1: one full word
        m_ready = 1'b1;
        clear_words();
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        wait_words("t1_count", 1, 40);
        check("t1_data", wq_data[0], 32'h44332211);
        check("t1_keep", {28'd0, wq_keep[0]}, 32'h0000000F);
        repeat (3) step();
        check("t1_empty", {31'd0, fifo_empty}, 32'd1);

        // 2: two words, backpressure on the first
        m_ready = 1'b0;
        clear_words();
        for (int i = 0; i < 8; i++) push(8'hA0 + 8'(i));
        wait_valid("t2_valid", 40);
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_data", m_data, 32'hA3A2A1A0);
            check("t2_hold_keep", {28'd0, m_keep}, 32'h0000000F);
            check("t2_hold_valid", {31'd0, m_valid}, 32'd1);
            step();
        end
        m_ready = 1'b1;
        wait_words("t2_count", 2, 40);
        check("t2_w0", wq_data[0], 32'hA3A2A1A0);
        check("t2_w1", wq_data[1], 32'hA7A6A5A4);
        check("t2_k1", {28'd0, wq_keep[1]}, 32'h0000000F);

        // 3: partial word via flush
        repeat (3) step();
        clear_words();
        push(8'h5A); push(8'hC3);
        wait_keep("t3_captured", 4'h3, 10);
        check("t3_no_early", {31'd0, m_valid}, 32'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_words("t3_count", 1, 10);
        check("t3_data", wq_data[0], 32'h0000C35A);
        check("t3_keep", {28'd0, wq_keep[0]}, 32'h00000003);

        // 4: partial word via idle timeout, 16 cycles after capture
        repeat (3) step();
        clear_words();
        push(8'h7E);
        wait_keep("t4_captured", 4'h1, 10);
        for (int n = 1; n <= 16; n++) begin
            step();
            if (n == 15) check("t4_not_yet", {31'd0, m_valid}, 32'd0);
            if (n == 16) check("t4_valid_at16", {31'd0, m_valid}, 32'd1);
        end
        wait_words("t4_count", 1, 5);
        check("t4_data", wq_data[0], 32'h0000007E);
        check("t4_keep", {28'd0, wq_keep[0]}, 32'h00000001);

        // 5: continuous writer, 32 bytes
        repeat (3) step();
        clear_words();
        for (int i = 0; i < 32; i++) bytes5[i] = 8'(i * 37 + 5);
        for (int i = 0; i < 32; i++) push(bytes5[i]);
        wait_words("t5_count", 8, 100);
        for (int w = 0; w < 8; w++) begin
            exp_w = {bytes5[4*w+3], bytes5[4*w+2], bytes5[4*w+1], bytes5[4*w]};
            check("t5_word", wq_data[w], exp_w);
        end
        check("t5_renb_consec", renb_consec, 0);
        check("t5_renb_empty", renb_empty, 0);

        // 6: reset while holding a word in EMIT
        repeat (3) step();
        m_ready = 1'b0;
        clear_words();
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        wait_valid("t6_valid", 40);
        reset = 1'b1;
        #1;
        check("t6_rst_valid", {31'd0, m_valid}, 32'd0);
        check("t6_rst_data", m_data, 32'd0);
        check("t6_rst_keep", {28'd0, m_keep}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        m_ready = 1'b1;
        push(8'h55); push(8'h66); push(8'h77); push(8'h88);
        wait_words("t6_count", 1, 40);
        check("t6_data", wq_data[0], 32'h88776655);
        check("t6_keep", {28'd0, wq_keep[0]}, 32'h0000000F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
